boolfun_mux_sequencer: RTL

//  Sequencer for the 4:1-mux Boolean-function datapath (3 variables A,B,C; A,B drive the mux select).
//  On start it latches a mux data-input configuration and drives input vectors {A,B,C}=0..7 through
//  the shared mux evaluator, one vector at a time.
//  It captures F for each vector into an 8-bit truth table and compares the table with an expected value.

---
 rtl/boolfun_pkg.sv | 32 +++
 rtl/boolfun_mux_sequencer_if.sv | 28 ++
 rtl/boolfun_mux_sequencer_mux4_fn.sv | 24 ++
 rtl/boolfun_mux_sequencer.sv | 126 ++++++++++++
 4 files changed

// File: rtl/boolfun_pkg.sv
// Shared types and constants for the 4:1-mux Boolean-function sequencer.
// Holds the FSM encoding, the mux data-input codes and the code decoder.
package boolfun_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] CFG_ZERO = 2'b00;
    localparam logic [1:0] CFG_ONE  = 2'b01;
    localparam logic [1:0] CFG_C    = 2'b10;
    localparam logic [1:0] CFG_NC   = 2'b11;

    localparam int         NVEC     = 8;
    localparam logic [2:0] LAST_VEC = 3'(NVEC - 1);

    // One mux data input: a constant, C itself or its complement.
    function automatic logic decode_cfg(input logic [1:0] code, input logic c);
        logic r;
        case (code)
            CFG_ZERO: r = 1'b0;
            CFG_ONE:  r = 1'b1;
            CFG_C:    r = c;
            CFG_NC:   r = ~c;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/boolfun_mux_sequencer_if.sv
// Control/result bundle between a config or self-test source and the sequencer.
// The master side issues sweeps; the slave side is the sequencer.
interface boolfun_mux_sequencer_if;
    import boolfun_pkg::*;

    logic                start;
    logic                abort;
    logic [7:0]          cfg;
    logic [NVEC-1:0]     exp_tt;
    logic [2:0]          vec;
    logic                f;
    logic                vec_valid;
    logic [NVEC-1:0]     tt_out;
    logic                busy;
    logic                done;
    logic                match;

    modport master (
        output start, abort, cfg, exp_tt,
        input  vec, f, vec_valid, tt_out, busy, done, match
    );

    modport slave (
        input  start, abort, cfg, exp_tt,
        output vec, f, vec_valid, tt_out, busy, done, match
    );

endinterface

// File: rtl/boolfun_mux_sequencer_mux4_fn.sv
// Combinational Boolean function of A,B,C built from a 4:1 mux with {A,B} as select.
// Each data input comes from a 2-bit code in cfg.
module mux4_fn
    import boolfun_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [7:0] cfg,
    output logic       f
);

    logic [3:0] data_in;

    always_comb begin
        data_in = '0;
        for (int i = 0; i < 4; i++) begin
            data_in[i] = decode_cfg(cfg[2*i +: 2], c);
        end
    end

    assign f = data_in[{a, b}];

endmodule

// File: rtl/boolfun_mux_sequencer.sv
// Sweeps {A,B,C}=0..7 through the mux evaluator, builds the truth table and
// compares it with an expected table at the end of the sweep.
module boolfun_mux_sequencer
    import boolfun_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    boolfun_mux_sequencer_if.slave   bus
);

    localparam int CW = 4;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   settle_cnt;
    logic [2:0]      vec;
    logic [7:0]      cfg_q;
    logic [NVEC-1:0] tt_out;
    logic            match;
    logic            f;
    logic            last_settle;
    logic            start_ok;

    mux4_fn u_fn (
        .a   (vec[2]),
        .b   (vec[1]),
        .c   (vec[0]),
        .cfg (cfg_q),
        .f   (f)
    );

    assign last_settle = (settle_cnt == SETTLE_LAST);
    assign start_ok    = bus.start && !bus.abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort takes priority everywhere, including over a simultaneous start in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                if (bus.abort) begin
                    state_nxt = IDLE;
                end else if (last_settle && vec == LAST_VEC) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            vec        <= '0;
            cfg_q      <= '0;
            tt_out     <= '0;
            match      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        cfg_q      <= bus.cfg;
                        tt_out     <= '0;
                        match      <= 1'b0;
                        vec        <= '0;
                        settle_cnt <= '0;
                    end
                end
                EVAL: begin
                    if (bus.abort) begin
                        vec        <= '0;
                        tt_out     <= '0;
                        match      <= 1'b0;
                        settle_cnt <= '0;
                    end else if (last_settle) begin
                        tt_out[vec] <= f;
                        settle_cnt  <= '0;
                        // Hold on the last vector so a sweep never rolls over.
                        if (vec != LAST_VEC) begin
                            vec <= vec + 3'd1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.abort) begin
                        vec    <= '0;
                        tt_out <= '0;
                        match  <= 1'b0;
                    end else begin
                        match <= (tt_out == bus.exp_tt);
                    end
                end
                default: begin
                    settle_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.vec       = vec;
    assign bus.f         = f;
    assign bus.tt_out    = tt_out;
    assign bus.match     = match;
    assign bus.vec_valid = (state == EVAL) && last_settle;
    assign bus.done      = (state == DONE) && !bus.abort;
    assign bus.busy      = (state != IDLE);

endmodule
